updn_ramp_ctrl: RTL and testbench
=================================

// Module: updn_ramp_ctrl
// PURPOSE
//   Sequencer that drives the en/down controls of an external up/down counter (cnt feedback
//   returned) to produce triangle ramps lo -> hi -> lo, with a programmable dwell at each turn
//   point and a programmable number of ramp cycles. Sits between a control/register interface
//   (start/abort, limits) and one up/down counter instance of the same WIDTH.
// PARAMETERS
//   WIDTH    8  counter width; lo, hi, cnt share this width
//   DWELL_W  8  width of dwell-cycle setting
//   NCYC_W   8  width of ramp-cycle count; 0 = run until abort
// PORTS
//   clk50m    in   1        50 MHz clock, single clock domain
//   rst       in   1        synchronous reset, active-high
//   start     in   1        start request, sampled in IDLE only
//   abort     in   1        stop immediately, any state
//   lo        in   WIDTH    lower turn point (unsigned)
//   hi        in   WIDTH    upper turn point (unsigned), must be > lo
//   dwell     in   DWELL_W  hold time at each turn point = dwell+1 cycles
//   ncyc      in   NCYC_W   number of full lo->hi->lo cycles; 0 = infinite
//   cnt       in   WIDTH    current value of the driven counter
//   cnt_en    out  1        counter enable (combinational from state, cnt, abort)
//   cnt_down  out  1        counter direction, 1 = decrement
//   busy      out  1        high in every state except IDLE
//   done      out  1        1-cycle pulse, normal completion
//   err       out  1        1-cycle pulse, start rejected (lo >= hi)
// BEHAVIOUR
//   - Reset: state IDLE; cnt_en=cnt_down=busy=done=err=0; latched lo/hi/dwell/ncyc, dwell timer
//     and cycle counter = 0. Reset in any state aborts with no done pulse.
//   - Settings latched on accepted start; input changes while busy are ignored.
//   - States: IDLE, SEEK, UP, HOLD_HI, DOWN, HOLD_LO, DONE.
//   - IDLE: start & lo<hi -> SEEK (latch settings, cycle counter=0); start & lo>=hi -> err pulse
//     next cycle, stay IDLE. start while busy ignored.
//   - SEEK: cnt_en = (cnt!=lo_q), cnt_down = (cnt>lo_q); cnt==lo_q -> UP.
//   - UP: cnt_en = (cnt!=hi_q), cnt_down=0; cnt==hi_q -> HOLD_HI, load dwell timer.
//   - HOLD_HI: cnt_en=0; lasts exactly dwell_q+1 cycles -> DOWN.
//   - DOWN: cnt_en = (cnt!=lo_q), cnt_down=1; cnt==lo_q -> increment cycle counter; if ncyc_q!=0
//     and new count==ncyc_q -> DONE, else HOLD_LO.
//   - HOLD_LO: cnt_en=0; dwell_q+1 cycles -> UP.
//   - DONE: done=1, busy=1, cnt_en=0 for one cycle -> IDLE.
//   - The compare gating of cnt_en guarantees the counter never passes lo_q/hi_q: no overshoot,
//     no wrap-around.
//   - abort: cnt_en forced 0 in the same cycle (combinational); next state IDLE; no done.
//     abort has priority over start and over all transitions.
//   - Cycle counter saturates at all-ones in infinite mode (ncyc_q=0); never ends without abort.
//   - cnt_down = 0 whenever cnt_en = 0.
//   - Latency: start -> busy 1 cycle. UP phase holds cnt_en high for exactly hi_q-lo_q cycles;
//     DOWN phase likewise.
// TESTING
//   1. counter=2, lo=2, hi=5, dwell=1, ncyc=1, start -> en pulses 3 up, 2-cycle hold, 3 down,
//      single done pulse, cnt ends at 2, busy drops.
//   2. counter=200, lo=10, hi=20, start -> SEEK decrements to 10 (cnt_down=1), then ramps
//      10..20; cnt never <10 or >20.
//   3. lo=7, hi=7 (and lo=9, hi=3), start -> err pulse, busy stays 0, cnt_en never set.
//   4. ncyc=0, run 5 cycles then abort mid-UP -> cnt_en=0 same cycle, IDLE next, no done.
//   5. lo=0, hi=255 (WIDTH=8), dwell=0, ncyc=2 -> full-range ramps, 1-cycle holds, no wrap,
//      done after second return to 0.
//   6. start pulsed while busy; rst asserted mid-DOWN -> start ignored; all outputs 0 the
//      cycle after rst, IDLE.

Source files
------------

// File: rtl/updn_ramp_ctrl_if.sv
// Control/status bundle between a ramp sequencer and its owner, including the
// enable/direction pair to the external up/down counter and its count feedback.
interface updn_ramp_ctrl_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 8,
   parameter int unsigned NCYC_W  = 8
);
   logic               start;
   logic               abort;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [DWELL_W-1:0] dwell;
   logic [NCYC_W-1:0]  ncyc;
   logic [WIDTH-1:0]   cnt;
   logic               cnt_en;
   logic               cnt_down;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, abort, lo, hi, dwell, ncyc, cnt,
      input  cnt_en, cnt_down, busy, done, err
   );

   modport slave (
      input  start, abort, lo, hi, dwell, ncyc, cnt,
      output cnt_en, cnt_down, busy, done, err
   );
endinterface

// File: rtl/updn_ramp_ctrl.sv
// Triangle-ramp sequencer: steers an external up/down counter lo -> hi -> lo with a dwell
// at each turn point, for a programmed number of cycles (0 = until abort).
module updn_ramp_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 8,
   parameter int unsigned NCYC_W  = 8
) (
   input logic               clk50m,
   input logic               rst,
   updn_ramp_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      StIdle, StSeek, StUp, StHoldHi, StDown, StHoldLo, StDone
   } state_e;

   localparam logic [DWELL_W-1:0] DwellOne = 1;
   localparam logic [NCYC_W-1:0]  CycOne   = 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [NCYC_W-1:0]  ncyc_q, ncyc_d;
   logic [DWELL_W-1:0] tmr_q, tmr_d;
   logic [NCYC_W-1:0]  cyc_q, cyc_d;
   logic               err_q, err_d;
   logic [NCYC_W-1:0]  cyc_inc;
   logic               en, down, busy, done;

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state_q <= StIdle;
         lo_q    <= '0;
         hi_q    <= '0;
         dwell_q <= '0;
         ncyc_q  <= '0;
         tmr_q   <= '0;
         cyc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dwell_q <= dwell_d;
         ncyc_q  <= ncyc_d;
         tmr_q   <= tmr_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
      end
   end

   // Saturation only matters in infinite mode; a finite run reaches ncyc_q first.
   assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CycOne;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dwell_d = dwell_q;
      ncyc_d  = ncyc_q;
      tmr_d   = tmr_q;
      cyc_d   = cyc_q;
      err_d   = 1'b0;
      if (bus.abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (bus.lo < bus.hi) begin
                     lo_d    = bus.lo;
                     hi_d    = bus.hi;
                     dwell_d = bus.dwell;
                     ncyc_d  = bus.ncyc;
                     cyc_d   = '0;
                     state_d = StSeek;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StSeek: begin
               if (bus.cnt == lo_q) state_d = StUp;
            end
            StUp: begin
               if (bus.cnt == hi_q) begin
                  tmr_d   = dwell_q;
                  state_d = StHoldHi;
               end
            end
            StHoldHi: begin
               if (tmr_q == '0) state_d = StDown;
               else             tmr_d   = tmr_q - DwellOne;
            end
            StDown: begin
               if (bus.cnt == lo_q) begin
                  cyc_d = cyc_inc;
                  if ((ncyc_q != '0) && (cyc_inc == ncyc_q)) begin
                     state_d = StDone;
                  end else begin
                     tmr_d   = dwell_q;
                     state_d = StHoldLo;
                  end
               end
            end
            StHoldLo: begin
               if (tmr_q == '0) state_d = StUp;
               else             tmr_d   = tmr_q - DwellOne;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Compare gating stops the counter exactly on the turn point: no overshoot, no wrap.
   always_comb begin
      en   = 1'b0;
      down = 1'b0;
      done = 1'b0;
      busy = (state_q != StIdle);
      unique case (state_q)
         StSeek: begin
            en   = (bus.cnt != lo_q);
            down = (bus.cnt > lo_q);
         end
         StUp: begin
            en   = (bus.cnt != hi_q);
         end
         StDown: begin
            en   = (bus.cnt != lo_q);
            down = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
      if (bus.abort) en = 1'b0;
      down = down & en;
   end

   assign bus.cnt_en   = en;
   assign bus.cnt_down = down;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_updn_ramp_ctrl.sv
// Scoreboarded bench: an up/down counter model closes the loop; each done/err event is
// matched against a queued expectation of final count, step counts, busy length and range.
module tb_updn_ramp_ctrl;

   logic       clk50m = 1'b0;
   logic       rst    = 1'b1;
   logic       cnt_load;
   logic [7:0] cnt_init;
   logic [7:0] cnt_r;

   always #10 clk50m = ~clk50m;

   updn_ramp_ctrl_if #(.WIDTH(8), .DWELL_W(8), .NCYC_W(8)) bus ();

   updn_ramp_ctrl #(.WIDTH(8), .DWELL_W(8), .NCYC_W(8)) dut (
      .clk50m (clk50m),
      .rst    (rst),
      .bus    (bus)
   );

   always @(posedge clk50m) begin
      if (cnt_load)         cnt_r <= cnt_init;
      else if (bus.cnt_en)  cnt_r <= bus.cnt_down ? cnt_r - 8'd1 : cnt_r + 8'd1;
   end
   assign bus.cnt = cnt_r;

   typedef struct {
      int is_err;
      int cnt;
      int up;
      int dn;
      int bcyc;
      int mn;
      int mx;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int is_err, input int c, input int up, input int dn,
                       input int bc, input int mn, input int mx);
      exp_t e;
      e.is_err = is_err; e.cnt = c; e.up = up; e.dn = dn; e.bcyc = bc; e.mn = mn; e.mx = mx;
      sbq.push_back(e);
   endtask

   // Monitor: accumulates per-run statistics and checks them at each done/err pulse.
   int up_c = 0, dn_c = 0, bc = 0, mn = 1000, mx = -1;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk50m);
         if (rst) begin
            up_c = 0; dn_c = 0; bc = 0; mn = 1000; mx = -1;
         end else begin
            if (bus.busy) bc++;
            if (bus.cnt_en) begin
               if (bus.cnt_down) dn_c++;
               else              up_c++;
            end
            if (up_c > 0) begin
               if (int'(bus.cnt) < mn) mn = int'(bus.cnt);
               if (int'(bus.cnt) > mx) mx = int'(bus.cnt);
            end
            if (bus.done || bus.err) begin
               if (sbq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_event: done=%0b err=%0b, expected no event",
                           bus.done, bus.err);
               end else begin
                  e = sbq.pop_front();
                  check("event_is_err", int'(bus.err), e.is_err);
                  check("event_done", int'(bus.done), 1 - e.is_err);
                  check("end_cnt", int'(bus.cnt), e.cnt);
                  check("up_steps", up_c, e.up);
                  check("down_steps", dn_c, e.dn);
                  check("busy_cycles", bc, e.bcyc);
                  if (e.is_err == 0) begin
                     check("ramp_min", mn, e.mn);
                     check("ramp_max", mx, e.mx);
                  end
               end
               up_c = 0; dn_c = 0; bc = 0; mn = 1000; mx = -1;
            end else if (!bus.busy) begin
               up_c = 0; dn_c = 0; bc = 0; mn = 1000; mx = -1;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk50m);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      cnt_init = v;
      cnt_load = 1'b1;
      tick(1);
      cnt_load = 1'b0;
   endtask

   task automatic run(input logic [7:0] l, input logic [7:0] h, input logic [7:0] d,
                      input logic [7:0] n);
      bus.lo = l; bus.hi = h; bus.dwell = d; bus.ncyc = n;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (sbq.size() != 0 && k < budget) begin
         tick(1);
         k++;
      end
      check(name, sbq.size(), 0);
      sbq.delete();
      tick(2);
   endtask

   initial begin
      bit found;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.ncyc = '0;
      cnt_load = 1'b1; cnt_init = 8'd0;
      tick(3);
      check("rst_cnt_en", int'(bus.cnt_en), 0);
      check("rst_cnt_down", int'(bus.cnt_down), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err", int'(bus.err), 0);
      rst = 1'b0;
      cnt_load = 1'b0;
      tick(2);

      // Basic ramp 2..5, dwell 1, one cycle.
      load(8'd2);
      push(0, 2, 3, 3, 12, 2, 5);
      run(8'd2, 8'd5, 8'd1, 8'd1);
      check("busy_after_start", int'(bus.busy), 1);
      drain("t1_drain", 100);
      check("t1_idle", int'(bus.busy), 0);

      // Seek down from 200 into window 10..20.
      load(8'd200);
      push(0, 10, 10, 200, 215, 10, 20);
      run(8'd10, 8'd20, 8'd0, 8'd1);
      drain("t2_drain", 400);

      // Rejected starts: equal and inverted limits.
      push(1, 10, 0, 0, 0, 0, 0);
      run(8'd7, 8'd7, 8'd0, 8'd1);
      drain("t3a_drain", 10);
      push(1, 10, 0, 0, 0, 0, 0);
      run(8'd9, 8'd3, 8'd0, 8'd1);
      drain("t3b_drain", 10);

      // Full-range ramp, 1-cycle holds, two cycles.
      load(8'd0);
      push(0, 0, 510, 510, 1029, 0, 255);
      run(8'd0, 8'd255, 8'd0, 8'd2);
      drain("t5_drain", 3000);

      // Infinite mode, abort mid-UP after several cycles.
      load(8'd3);
      run(8'd3, 8'd6, 8'd0, 8'd0);
      tick(60);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         if (bus.cnt_en && !bus.cnt_down && bus.cnt == 8'd4) found = 1'b1;
         else tick(1);
      end
      check("t4_found_up", int'(found), 1);
      bus.abort = 1'b1;
      #1;
      check("t4_abort_en_now", int'(bus.cnt_en), 0);
      check("t4_abort_busy_now", int'(bus.busy), 1);
      tick(1);
      bus.abort = 1'b0;
      check("t4_idle_next", int'(bus.busy), 0);
      check("t4_cnt_held", int'(bus.cnt), 4);
      tick(20);
      check("t4_still_idle", int'(bus.busy), 0);

      // Start pulsed while busy with different settings must be ignored.
      load(8'd2);
      push(0, 2, 3, 3, 12, 2, 5);
      run(8'd2, 8'd5, 8'd1, 8'd1);
      tick(3);
      bus.lo = 8'd0; bus.hi = 8'd200; bus.ncyc = 8'd3;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      drain("t6a_drain", 100);

      // Reset mid-DOWN: everything drops, no done.
      load(8'd2);
      run(8'd2, 8'd5, 8'd1, 8'd1);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (bus.cnt_en && bus.cnt_down) found = 1'b1;
         else tick(1);
      end
      check("t6_found_down", int'(found), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t6_rst_en", int'(bus.cnt_en), 0);
      check("t6_rst_down", int'(bus.cnt_down), 0);
      check("t6_rst_busy", int'(bus.busy), 0);
      check("t6_rst_done", int'(bus.done), 0);
      check("t6_rst_err", int'(bus.err), 0);
      tick(20);
      check("t6_still_idle", int'(bus.busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
